// File: rtl/x_alp_uart_sink.sv
// -----------------------------------------------------------------------------
// x_alp_uart_sink
//
// UART receive sink for the SoC console line. It deserializes 8N1 frames into
// bytes and queues them in a small show-ahead FIFO that is drained over a
// valid/ready interface. Framing errors are reported as a one-cycle pulse.
// A byte that arrives while the FIFO is full and not being popped is dropped,
// and the sticky overflow flag is raised.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (integer >= 4)
//   FIFO_DEPTH   : byte FIFO entries (power of two >= 2)
//
// Ports
//   clk_i        : single clock
//   rst_i        : asynchronous, active-high reset
//   enable_i     : receiver enable; low forces the receiver idle
//   uart_rx_i    : serial line, asynchronous to clk_i, idles high
//   data_o       : byte at the FIFO head (0 while the FIFO is empty)
//   valid_o      : FIFO non-empty
//   ready_i      : consumer accepts data_o
//   count_o      : current FIFO occupancy
//   frame_err_o  : one-cycle pulse when a stop bit samples low
//   overflow_o   : sticky flag, a byte was dropped because the FIFO was full
//   clear_i      : clears overflow_o (a same-cycle overflow takes priority)
//   state_o      : receiver FSM state, for debug and checker binding
//
// Handshake: a byte is transferred on every rising clk_i edge where
// valid_o && ready_i. While valid_o is high and ready_i is low, data_o and
// count_o hold their values (except count_o rising on a receive). ready_i
// may be high while valid_o is low; that cycle transfers nothing.
// -----------------------------------------------------------------------------
module x_alp_uart_sink #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic                          uart_rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          clear_i,
    output logic [2:0]                    state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Counter reload values. The start-bit wait is half a bit so that every
    // following sample lands near the middle of its bit.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. rx_meta/rx_s form the two-flop synchronizer; rx_q
    // is one cycle older than rx_s and is used only for edge detection.
    // All three reset to the idle (high) line level so that reset release on
    // an idle line does not look like a start edge.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;
    logic rx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    logic fall_edge;
    assign fall_edge = rx_q && !rx_s;

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            cnt_zero;
    logic            push;

    assign cnt_zero = (bit_cnt == '0);

    // A good stop bit pushes the assembled byte in the stop-sample cycle.
    // enable_i low suppresses the push because the FSM is being forced idle.
    assign push = enable_i && (state == ST_STOP) && cnt_zero && rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (!enable_i) begin
                // Abandon any partial frame silently.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall_edge) begin
                            bit_cnt <= HALF_LOAD;
                            state   <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (cnt_zero) begin
                            if (rx_s) begin
                                // Line went back high before mid-start-bit:
                                // treat as a glitch, not a frame.
                                state <= ST_IDLE;
                            end else begin
                                bit_cnt <= FULL_LOAD;
                                bit_idx <= '0;
                                state   <= ST_DATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_zero) begin
                            // LSB arrives first, so shift right from the top.
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= FULL_LOAD;
                            if (bit_idx == 3'd7) begin
                                state <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_zero) begin
                            // Leaving at mid-stop-bit lets a back-to-back
                            // start edge be caught from IDLE.
                            if (rx_s) begin
                                state <= ST_IDLE;
                            end else begin
                                frame_err_o <= 1'b1;
                                state       <= ST_BREAK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Hold off until the line returns high so a stuck-low
                        // line does not retrigger reception.
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

    // -------------------------------------------------------------------------
    // Show-ahead byte FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    assign full    = (count == DEPTH_C);
    assign pop     = valid_o && ready_i;
    // When full, a same-cycle pop frees the slot the push needs.
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    // Storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            // A new overflow beats a same-cycle clear.
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clear_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign valid_o = (count != '0);
    assign count_o = count;
    assign data_o  = valid_o ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/x_alp_uart_sink.md
# x_alp_uart_sink

UART receive sink that sits directly downstream of the SoC's `uart_tx_o` pin. It deserializes 8N1 frames into bytes and buffers them in a small show-ahead FIFO with a valid/ready output. It flags framing errors and FIFO overflow. Testbenches and the FPGA console bridge use it to consume SoC console output without a host-side UART model.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be an integer ≥ 4.
- `FIFO_DEPTH`, default 8: byte FIFO entries. Must be a power of two ≥ 2.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: receiver enable. When low, no frames are accepted.
- `uart_rx_i` in 1: serial line, asynchronous to `clk_i`, idles high. Connects to the SoC `uart_tx_o`.
- `data_o` out 8: byte at the FIFO head.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer accepts `data_o`. Pop occurs when `valid_o && ready_i`.
- `count_o` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `frame_err_o` out 1: one-cycle pulse when a stop bit samples low.
- `overflow_o` out 1: sticky flag, set when a byte is dropped because the FIFO is full.
- `clear_i` in 1: clears `overflow_o`.

## Operation
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, synchronizer flops at 1.
- Synchronizer: `uart_rx_i` passes through 2 flops to produce `rx_s`. A third flop holds `rx_q` for edge detection. A falling edge is `rx_q && !rx_s`.
- FSM states and transitions:
  - IDLE: on falling edge with `enable_i` high, load bit counter with CLKS_PER_BIT/2−1 (integer division) and go to START.
  - START: when the counter reaches 0, sample `rx_s`.
    - If 1 (glitch): return to IDLE with no error.
    - If 0: reload CLKS_PER_BIT−1 and go to DATA with bit index 0.
  - DATA: on each counter expiry, shift `rx_s` into bit [7] of the shift register, which shifts right so data arrives LSB first. Reload the counter.
    - After index 7, go to STOP.
  - STOP: on counter expiry, sample `rx_s`.
    - If 1: push the shift register and go to IDLE.
    - If 0: pulse `frame_err_o`, drop the byte, and go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line from retriggering reception.
- Leaving the stop bit at its midpoint allows back-to-back frames; the next start edge is detected normally.
- `enable_i` low in any state forces IDLE on the next edge. A partial frame is discarded with no error and no push. FIFO contents and flags are retained.
- FIFO push/pop rules:
  - Push when not full: occupancy +1.
  - Push when full with a simultaneous pop: both occur and occupancy is unchanged.
  - Push when full without a pop: byte dropped, `overflow_o` set.
  - Pop when empty: ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- `clear_i` clears `overflow_o` on the next edge. If an overflow occurs in the same cycle as `clear_i`, the overflow wins and `overflow_o` stays 1.
- `data_o` is stable while `valid_o && !ready_i`.

## Timing
- Let E be the cycle in which the falling edge is detected, 2 cycles after the pin transitions. Let H = CLKS_PER_BIT/2.
- Sample points:
  - Start bit: E+H.
  - Data bit i: E+H+(i+1)·CLKS_PER_BIT.
  - Stop bit: E+H+9·CLKS_PER_BIT.
- Push occurs in the stop-sample cycle. `valid_o`, `data_o` and `count_o` update on the following edge.
- `frame_err_o` is high for exactly the cycle after the stop sample.
- Pop: `count_o` decrements and the next entry appears on `data_o` the cycle after the handshake.
- Reset asserted mid-frame clears everything immediately, including the FIFO. After release, reception restarts only on a new falling edge.

## Test plan
- CLKS_PER_BIT=16, send 0x55 then 0xA3 back-to-back, `ready_i`=0 → `count_o`=2, `data_o`=0x55. Pop once → `data_o`=0xA3.
- Low pulse of 4 cycles on an idle line → no push, no `frame_err_o`, FSM returns to IDLE.
- Send 0x41 with the stop bit forced low, then hold the line low for 50 bit times → one `frame_err_o` pulse, FIFO empty, no further frames until the line goes high. A following 0x42 is received correctly.
- FIFO_DEPTH=4, send 5 bytes 0x01..0x05 with `ready_i`=0 → `count_o`=4, `overflow_o`=1, FIFO holds 0x01..0x04. Assert `clear_i` → `overflow_o`=0.
- With the FIFO full, hold `ready_i`=1 during the 5th stop sample → 0x05 is stored, `overflow_o` stays 0, `count_o` stays 4.
- Assert `rst_i` during data bit 3 of a frame → all outputs 0 immediately. The next full frame 0x7E is received correctly. Deassert `enable_i` mid-frame → no push and no error.
